// File: rtl/mem_bus_responder_if.sv
// Memory-port bus between a cache (master) and a line-wide memory responder (slave).
//
// Handshake: each channel transfers exactly on a cycle where valid && ready are both
// high at the rising clock edge. A source holds valid and its payload stable until the
// transfer happens; ready never depends combinationally on valid of the same channel.
interface mem_bus_responder_if #(
  parameter int DATA_SIZE  = 64,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH  = 8
);
  logic                   mem_req_valid;
  logic                   mem_req_rw;
  logic [ADDR_WIDTH-1:0]  mem_req_addr;
  logic [DATA_SIZE*8-1:0] mem_req_data;
  logic [DATA_SIZE-1:0]   mem_req_byteen;
  logic [TAG_WIDTH-1:0]   mem_req_tag;
  logic                   mem_req_ready;

  logic                   mem_rsp_valid;
  logic [DATA_SIZE*8-1:0] mem_rsp_data;
  logic [TAG_WIDTH-1:0]   mem_rsp_tag;
  logic                   mem_rsp_ready;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_byteen, mem_req_tag,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    output mem_rsp_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_byteen, mem_req_tag,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
    input  mem_rsp_ready
  );
endinterface

// File: rtl/mem_bus_responder.sv
// Fixed-latency line memory responder. Reads travel through a LATENCY-1 deep shift
// pipeline into an in-order fall-through response FIFO; admission is credit based so
// the FIFO can never overflow while responses are back-pressured.
module mem_bus_responder #(
  parameter int DATA_SIZE      = 64,
  parameter int ADDR_WIDTH     = 26,
  parameter int TAG_WIDTH      = 8,
  parameter int DEPTH          = 1024,
  parameter int LATENCY        = 4,
  parameter int RSP_QUEUE_SIZE = 8
) (
  input  logic                clk,
  input  logic                reset,
  mem_bus_responder_if.slave  bus,
  output logic [31:0]         perf_reads,
  output logic [31:0]         perf_writes
);
  localparam int DW    = DATA_SIZE * 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(RSP_QUEUE_SIZE + 1);
  localparam int PTR_W = (RSP_QUEUE_SIZE > 1) ? $clog2(RSP_QUEUE_SIZE) : 1;
  localparam int PS    = LATENCY - 1;
  localparam int PA    = (PS > 0) ? PS : 1;
  localparam logic [CNT_W-1:0] Q_FULL   = CNT_W'(RSP_QUEUE_SIZE);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_QUEUE_SIZE - 1);

  // Storage (contents survive reset)
  logic [DW-1:0]        mem_q       [DEPTH];
  logic [DW-1:0]        fifo_data_q [RSP_QUEUE_SIZE];
  logic [TAG_WIDTH-1:0] fifo_tag_q  [RSP_QUEUE_SIZE];

  // Read pipeline
  logic                 pipe_valid_q [PA];
  logic                 pipe_valid_d [PA];
  logic [DW-1:0]        pipe_data_q  [PA];
  logic [DW-1:0]        pipe_data_d  [PA];
  logic [TAG_WIDTH-1:0] pipe_tag_q   [PA];
  logic [TAG_WIDTH-1:0] pipe_tag_d   [PA];

  // FIFO control, credits and counters
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [31:0]      perf_reads_q, perf_reads_d, perf_writes_q, perf_writes_d;

  logic                 req_fire, rd_accept, wr_accept, rsp_fire;
  logic [IDX_W-1:0]     req_idx;
  logic [DW-1:0]        rd_line;
  logic                 push_valid;
  logic [DW-1:0]        push_data;
  logic [TAG_WIDTH-1:0] push_tag;
  logic                 unused_addr_hi;

  // Upper address bits alias onto the same line.
  assign req_idx        = bus.mem_req_addr[IDX_W-1:0];
  assign unused_addr_hi = ^bus.mem_req_addr[ADDR_WIDTH-1:IDX_W];
  assign rd_line        = mem_q[req_idx];

  // Ready depends only on reset and registered credit state.
  assign bus.mem_req_ready = !reset && (outstanding_q < Q_FULL);
  assign req_fire  = bus.mem_req_valid && bus.mem_req_ready;
  assign rd_accept = req_fire && !bus.mem_req_rw;
  assign wr_accept = req_fire && bus.mem_req_rw;

  assign bus.mem_rsp_valid = (fifo_cnt_q != '0);
  assign bus.mem_rsp_data  = fifo_data_q[rd_ptr_q];
  assign bus.mem_rsp_tag   = fifo_tag_q[rd_ptr_q];
  assign rsp_fire          = bus.mem_rsp_valid && bus.mem_rsp_ready;

  assign perf_reads  = perf_reads_q;
  assign perf_writes = perf_writes_q;

  // FIFO push source: last pipeline stage, or the array itself when LATENCY is 1.
  always_comb begin
    if (PS == 0) begin
      push_valid = rd_accept;
      push_data  = rd_line;
      push_tag   = bus.mem_req_tag;
    end else begin
      push_valid = pipe_valid_q[PA-1];
      push_data  = pipe_data_q[PA-1];
      push_tag   = pipe_tag_q[PA-1];
    end
  end

  // Next-state for pipeline, FIFO pointers, credits and perf counters.
  always_comb begin
    pipe_valid_d[0] = rd_accept;
    pipe_data_d[0]  = rd_line;
    pipe_tag_d[0]   = bus.mem_req_tag;
    for (int i = 1; i < PA; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_data_d[i]  = pipe_data_q[i-1];
      pipe_tag_d[i]   = pipe_tag_q[i-1];
    end
    wr_ptr_d = wr_ptr_q;
    if (push_valid) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    rd_ptr_d = rd_ptr_q;
    if (rsp_fire) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    fifo_cnt_d    = fifo_cnt_q + CNT_W'(push_valid) - CNT_W'(rsp_fire);
    outstanding_d = outstanding_q + CNT_W'(rd_accept) - CNT_W'(rsp_fire);
    perf_reads_d  = perf_reads_q + 32'(rd_accept);
    perf_writes_d = perf_writes_q + 32'(wr_accept);
  end

  // Control state: cleared immediately by reset, discarding reads in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PA; i++) begin
        pipe_valid_q[i] <= 1'b0;
        pipe_data_q[i]  <= '0;
        pipe_tag_q[i]   <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      outstanding_q <= '0;
      perf_reads_q  <= '0;
      perf_writes_q <= '0;
    end else begin
      for (int i = 0; i < PA; i++) begin
        pipe_valid_q[i] <= pipe_valid_d[i];
        pipe_data_q[i]  <= pipe_data_d[i];
        pipe_tag_q[i]   <= pipe_tag_d[i];
      end
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      outstanding_q <= outstanding_d;
      perf_reads_q  <= perf_reads_d;
      perf_writes_q <= perf_writes_d;
    end
  end

  // Array byte writes and FIFO entry writes; no reset so contents persist.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int b = 0; b < DATA_SIZE; b++) begin
        if (bus.mem_req_byteen[b]) mem_q[req_idx][b*8 +: 8] <= bus.mem_req_data[b*8 +: 8];
      end
    end
    if (push_valid) begin
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_tag_q[wr_ptr_q]  <= push_tag;
    end
  end

  // Credits make a push into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (reset) !(push_valid && (fifo_cnt_q == Q_FULL)));

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Line-wide, fixed-latency memory responder: the slave end of the cache cluster's memory-port protocol. Each instance accepts line-sized read and write requests on one memory port and returns read responses in order. It is used behind each cache memory port in simulation and FPGA on-chip builds. Credit-based admission guarantees that no response is ever dropped under response back-pressure.

## Interface

**Parameters**

- `DATA_SIZE`, 64: line size in bytes. Data width is `DATA_SIZE*8`; byte-enable width is `DATA_SIZE`.
- `ADDR_WIDTH`, 26: line-address width.
- `TAG_WIDTH`, 8: request/response tag width.
- `DEPTH`, 1024: number of stored lines. Must be a power of 2 and ≥ 2.
- `LATENCY`, 4: cycles from read acceptance to earliest `mem_rsp_valid`. Must be ≥ 1.
- `RSP_QUEUE_SIZE`, 8: response credits. Must be ≥ `LATENCY` for full throughput.

**Ports**

- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `mem_req_valid` in 1: request valid.
- `mem_req_rw` in 1: 1 = write, 0 = read.
- `mem_req_addr` in `ADDR_WIDTH`: line address.
- `mem_req_data` in `DATA_SIZE*8`: write data.
- `mem_req_byteen` in `DATA_SIZE`: write byte enables.
- `mem_req_tag` in `TAG_WIDTH`: request tag.
- `mem_req_ready` out 1: request accepted when `valid && ready`.
- `mem_rsp_valid` out 1: read response valid.
- `mem_rsp_data` out `DATA_SIZE*8`: read line.
- `mem_rsp_tag` out `TAG_WIDTH`: tag of the originating read.
- `mem_rsp_ready` in 1: response consumed when `valid && ready`.
- `perf_reads` out 32: count of accepted reads.
- `perf_writes` out 32: count of accepted writes.

## Operation

**Addressing**
- Index = `mem_req_addr[log2(DEPTH)-1:0]`. Upper address bits are ignored, so addresses alias modulo `DEPTH`.

**Writes**
- On acceptance, each byte with `byteen=1` is updated; bytes with `byteen=0` keep their value.
- A write produces no response.
- A write with all-zero `byteen` is accepted and has no effect.

**Reads**
- On acceptance, the array is sampled and `{data, tag}` enters a shift pipeline `LATENCY-1` stages deep, then pushes into an in-order response FIFO of `RSP_QUEUE_SIZE` entries.
- The FIFO is fall-through: its head drives `mem_rsp_*`.

**Read-after-write**
- A write accepted in cycle t is visible to a read accepted in cycle t+1 or later.
- Only one request is accepted per cycle, so no same-cycle hazard exists.

**Credits**
- `outstanding` counts reads in the pipeline plus FIFO occupancy. Width is `clog2(RSP_QUEUE_SIZE+1)`.
- It increments on read accept and decrements on response fire. Both events in the same cycle leave it unchanged.
- `mem_req_ready = !reset && (outstanding < RSP_QUEUE_SIZE)`, for reads and writes alike.
- `mem_req_ready` has no combinational path from `mem_req_*` or `mem_rsp_ready`.

**Ordering**
- Responses leave in read-acceptance order; tags are returned unmodified.

**Perf counters**
- Each counter increments by 1 per accepted request of its type and wraps modulo 2^32.

**Reset (asynchronous, any cycle)**
- Immediately: pipeline valids cleared, FIFO emptied, `outstanding`=0, perf counters=0.
- Array contents are retained and are undefined after power-up.
- Reads in flight at reset are discarded and never responded to.

## Timing

- Reset values: `mem_req_ready`=0 while `reset` is high; `mem_rsp_valid`=0; `mem_rsp_data`/`mem_rsp_tag` don't-care; perf counters 0.
- `mem_req_ready`=1 on the first cycle after reset deasserts.
- Read accepted at edge t with an empty FIFO: `mem_rsp_valid`=1 during cycle t+`LATENCY`.
- Sustained throughput is one request per cycle while `mem_rsp_ready`=1 and `RSP_QUEUE_SIZE` ≥ `LATENCY`.
- Once asserted, `mem_rsp_valid`, `mem_rsp_data` and `mem_rsp_tag` stay stable until the response fires.
- FIFO full is impossible by credit construction; an assertion checks that no push occurs when the FIFO is full.
- When `outstanding` = `RSP_QUEUE_SIZE`, ready is 0.
- A response fire at edge e raises ready in cycle e+1.

## Test plan

- **Write then read:** write addr 0x5, data pattern 0xA5 repeated, byteen all 1s, then read addr 0x5 with tag 0x3C next cycle → response 0xA5… with tag 0x3C exactly `LATENCY` cycles after read acceptance.
- **Partial write:** write 0x00… to addr 7, then write 0xFF… to addr 7 with byteen=0x0F, then read → bytes 0–3 = 0xFF, bytes 4–63 = 0x00.
- **Back-pressure:** `mem_rsp_ready`=0, issue 10 reads with tags 0–9 → exactly 8 accepted and ready drops to 0. Raise `mem_rsp_ready` → tags 0–7 return in order, then tags 8–9 are accepted and returned. `perf_reads`=10.
- **Streaming:** 64 back-to-back reads with `mem_rsp_ready`=1 → ready never drops, 64 in-order responses on consecutive cycles.
- **Aliasing:** write addr 0x3 followed by a read of addr 0x3 + `DEPTH` → the read returns the data written to addr 0x3.
- **Reset mid-flight:** 3 reads in flight, assert `reset` for 1 cycle → no responses emerge, `outstanding`=0, perf counters 0. A subsequent read of a previously written address returns the pre-reset data.
